// File: rtl/pipe_stage4_if.sv
// Handshake and data bundle for the interval-count update stage.
// slave is the stage's view; master is the view of whatever drives it.
interface pipe_stage4_if #(
    parameter int n             = 4096,
    parameter int para          = 16,
    parameter int parallel_size = 12
);
    localparam int step_w = $clog2(n) + 1;

    logic                            start_i;
    logic [para-1:0]                 stable_thresh_i;
    logic                            valid_i;
    logic                            ready_o;
    logic [parallel_size-1:0]        out_of_mode_interval_i;
    logic [parallel_size*para-1:0]   interval_cnt_i;
    logic                            valid_o;
    logic                            ready_i;
    logic [parallel_size*para-1:0]   interval_cnt_o;
    logic [parallel_size-1:0]        lane_stable_o;
    logic [step_w-1:0]               step_cnt_o;
    logic                            all_stable_o;
    logic                            done_o;

    modport slave (
        input  start_i, stable_thresh_i, valid_i, out_of_mode_interval_i,
               interval_cnt_i, ready_i,
        output ready_o, valid_o, interval_cnt_o, lane_stable_o, step_cnt_o,
               all_stable_o, done_o
    );

    modport master (
        output start_i, stable_thresh_i, valid_i, out_of_mode_interval_i,
               interval_cnt_i, ready_i,
        input  ready_o, valid_o, interval_cnt_o, lane_stable_o, step_cnt_o,
               all_stable_o, done_o
    );
endinterface

// File: rtl/pipe_stage4.sv
// Per-lane interval-count update with sticky stability flags and
// early termination once every lane is stable or n beats have been seen.
//
// state | meaning
// IDLE  | waiting for start, no beats accepted
// RUN   | accepting beats, updating counts and stability
// DONE  | sequence terminated, no beats accepted until start
module pipe_stage4 #(
    parameter int n             = 4096,
    parameter int para          = 16,
    parameter int parallel_size = 12
) (
    input logic         clk_i,
    input logic         rst_ni,
    pipe_stage4_if.slave bus
);
    localparam int step_w = $clog2(n) + 1;
    localparam logic [step_w-1:0] step_max = step_w'(n);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                        state, state_nxt;
    logic                          ready, accept, terminate;
    logic                          valid_q;
    logic [parallel_size*para-1:0] cnt_q, cnt_nxt;
    logic [parallel_size-1:0]      stable_q, stable_nxt;
    logic [step_w-1:0]             step_q, step_nxt;
    logic [para-1:0]               lane_cnt;

    // Per-lane count update (reset on out-of-interval, saturating increment) and stability set
    always_comb begin
        cnt_nxt    = '0;
        stable_nxt = stable_q;
        lane_cnt   = '0;
        for (int i = 0; i < parallel_size; i++) begin
            if (bus.out_of_mode_interval_i[i]) begin
                lane_cnt = '0;
            end else if (bus.interval_cnt_i[i*para +: para] == {para{1'b1}}) begin
                lane_cnt = {para{1'b1}};
            end else begin
                lane_cnt = bus.interval_cnt_i[i*para +: para] + 1'b1;
            end
            cnt_nxt[i*para +: para] = lane_cnt;
            if ((bus.stable_thresh_i != '0) && (lane_cnt >= bus.stable_thresh_i)) begin
                stable_nxt[i] = 1'b1;
            end
        end
        step_nxt = step_q + 1'b1;
    end

    // A start pulse always blocks acceptance so a beat never lands in the cleared sequence
    assign ready     = (state == RUN) && !bus.start_i && (!valid_q || bus.ready_i);
    assign accept    = bus.valid_i && ready;
    assign terminate = accept && ((&stable_nxt) || (step_nxt == step_max));

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start_i) state_nxt = RUN;
            end
            RUN: begin
                if (bus.start_i)     state_nxt = RUN;
                else if (terminate)  state_nxt = DONE;
            end
            DONE: begin
                if (bus.start_i) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register: load on accept, drain when downstream takes the beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                cnt_q   <= cnt_nxt;
            end else if (bus.ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Sequence state: sticky stable flags and step counter, cleared by start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_q <= '0;
            step_q   <= '0;
        end else if (bus.start_i) begin
            stable_q <= '0;
            step_q   <= '0;
        end else if (accept) begin
            stable_q <= stable_nxt;
            step_q   <= step_nxt;
        end
    end

    assign bus.ready_o        = ready;
    assign bus.valid_o        = valid_q;
    assign bus.interval_cnt_o = cnt_q;
    assign bus.lane_stable_o  = stable_q;
    assign bus.step_cnt_o     = step_q;
    assign bus.all_stable_o   = &stable_q;
    assign bus.done_o         = (state == DONE);
endmodule
